// File: rtl/add_subt_arbiter_pkg.sv
// Shared definitions for the add/subtract unit arbiter.
//   - FSM state encodings (kept as plain localparams for compatibility with
//     legacy tools that read the encodings numerically).
//   - Operation encodings driven to the add/subtract unit.
package add_subt_arbiter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StLaunch  = 3'd1;
  localparam state_t StWait    = 3'd2;
  localparam state_t StDone    = 3'd3;
  localparam state_t StRelease = 3'd4;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

endpackage

// File: rtl/add_subt_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - index with highest priority this round
//   idx_o   - first requester at or above ptr_i (with wrap-around) that is requesting
//   valid_o - at least one request is present
module add_subt_arbiter_rr_priority_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned GW    = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GW-1:0]    ptr_i,
  output logic [GW-1:0]    idx_o,
  output logic             valid_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [GW:0] cand;

  always_comb begin
    idx_o   = '0;
    cand    = '0;
    valid_o = |req_i;
    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (GW + 1)'(k);
      if (cand >= (GW + 1)'(N_REQ)) begin
        cand = cand - (GW + 1)'(N_REQ);
      end
      if (req_i[cand[GW-1:0]]) begin
        idx_o = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/add_subt_arbiter.sv
// Round-robin arbiter sharing one floating-point add/subtract unit between
// N_REQ requesters.
// Ports:
//   clk, reset              - clock and asynchronous active-high reset
//   req_in                  - level request per requester, held until its ready_out
//   operation_in            - per requester: 0 add, 1 subtract
//   data_a_in / data_b_in   - flattened operands, requester i at [i*W +: W]
//   ack_in                  - per requester: result taken
//   ready_out               - one-hot result-valid towards the granted requester
//   result_out              - registered result, shared
//   busy                    - arbiter is not idle
//   grant_id                - current or last granted requester
//   beg_add_subt            - start pulse to the unit
//   ack_add_subt            - result-consumed pulse to the unit
//   operation_add_subt,
//   data_a_add_subt,
//   data_b_add_subt         - latched operation and operands for the unit
//   ready_add_subt,
//   result_add_subt         - unit result handshake
module add_subt_arbiter
  import add_subt_arbiter_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned N_REQ = 2,
  parameter int unsigned GW    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] operation_in,
  input  logic [N_REQ*W-1:0] data_a_in,
  input  logic [N_REQ*W-1:0] data_b_in,
  input  logic [N_REQ-1:0] ack_in,
  output logic [N_REQ-1:0] ready_out,
  output logic [W-1:0]     result_out,
  output logic             busy,
  output logic [GW-1:0]    grant_id,
  output logic             beg_add_subt,
  output logic             ack_add_subt,
  output logic             operation_add_subt,
  output logic [W-1:0]     data_a_add_subt,
  output logic [W-1:0]     data_b_add_subt,
  input  logic             ready_add_subt,
  input  logic [W-1:0]     result_add_subt
);

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic          op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;

  logic [GW-1:0] pick_idx;
  logic          pick_valid;
  logic          ack_granted;

  add_subt_arbiter_rr_priority_picker #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_picker (
    .req_i   (req_in),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Only the granted requester's ack counts.
  always_comb begin
    ack_granted = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        ack_granted = ack_in[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == GW'(i)) begin
              op_d = operation_in[i] ? OpSub : OpAdd;
              a_d  = data_a_in[i*W +: W];
              b_d  = data_b_in[i*W +: W];
            end
          end
          state_d = StLaunch;
        end
      end
      // The unit only sees beg here; a ready now belongs to no transaction.
      StLaunch: state_d = StWait;
      StWait: begin
        if (ready_add_subt) begin
          res_d   = result_add_subt;
          state_d = StDone;
        end
      end
      StDone: begin
        if (ack_granted) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        rr_ptr_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    ready_out = '0;
    if (state_q == StDone) begin
      for (int i = 0; i < N_REQ; i++) begin
        ready_out[i] = (grant_q == GW'(i));
      end
    end
  end

  assign busy               = (state_q != StIdle);
  assign beg_add_subt       = (state_q == StLaunch);
  assign ack_add_subt       = (state_q == StRelease);
  assign grant_id           = grant_q;
  assign result_out         = res_q;
  assign operation_add_subt = op_q;
  assign data_a_add_subt    = a_q;
  assign data_b_add_subt    = b_q;

endmodule

// File: tb/tb_add_subt_arbiter.sv
// Self-checking bench for add_subt_arbiter (N_REQ=2): reset state, a vector
// table of single transactions, hand-written corner sequences, and a
// randomized run checked against a round-robin reference model.
module tb_add_subt_arbiter;

  localparam int NR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_in = '0;
  logic [1:0]  operation_in = '0;
  logic [63:0] data_a_in = '0;
  logic [63:0] data_b_in = '0;
  logic [1:0]  ack_in = '0;
  logic [1:0]  ready_out;
  logic [31:0] result_out;
  logic        busy;
  logic [0:0]  grant_id;
  logic        beg_add_subt;
  logic        ack_add_subt;
  logic        operation_add_subt;
  logic [31:0] data_a_add_subt;
  logic [31:0] data_b_add_subt;
  logic        ready_add_subt = 1'b0;
  logic [31:0] result_add_subt = '0;

  add_subt_arbiter #(
    .W     (32),
    .N_REQ (2),
    .GW    (1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_in             (req_in),
    .operation_in       (operation_in),
    .data_a_in          (data_a_in),
    .data_b_in          (data_b_in),
    .ack_in             (ack_in),
    .ready_out          (ready_out),
    .result_out         (result_out),
    .busy               (busy),
    .grant_id           (grant_id),
    .beg_add_subt       (beg_add_subt),
    .ack_add_subt       (ack_add_subt),
    .operation_add_subt (operation_add_subt),
    .data_a_add_subt    (data_a_add_subt),
    .data_b_add_subt    (data_b_add_subt),
    .ready_add_subt     (ready_add_subt),
    .result_add_subt    (result_add_subt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int rdy_cyc = 0;
  int cnt = 0;
  int unit_dly = 2;
  logic unit_en = 1'b0;
  logic use_ovr = 1'b0;
  logic [31:0] ovr_val = '0;

  logic [31:0] ra[NR];
  logic [31:0] rb[NR];
  logic        rop[NR];

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  op;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] res;
    int          dly;
    int          gid;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
    return op ? a - b : a + b;
  endfunction

  // Round-robin rule: first requesting index at or after ptr, wrapping.
  function automatic int rr_pick(input logic [1:0] r, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    data_a_in    = {ra[1], ra[0]};
    data_b_in    = {rb[1], rb[0]};
    operation_in = {rop[1], rop[0]};
  endtask

  // Model of the add/subtract unit: ready after unit_dly cycles, held until acked.
  task automatic unit_step();
    if (unit_en) begin
      if (ack_add_subt) ready_add_subt = 1'b0;
      if (beg_add_subt) cnt = unit_dly;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ready_add_subt  = 1'b1;
          result_add_subt = use_ovr ? ovr_val :
                            unit_fn(data_a_add_subt, data_b_add_subt, operation_add_subt);
          rdy_cyc = cyc;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    unit_step();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_out == 2'b00 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Manual unit: called with LAUNCH visible; completes and releases the transaction.
  task automatic finish_txn(input string nm, input logic [1:0] oh, input logic [31:0] r);
    tick();
    ready_add_subt  = 1'b1;
    result_add_subt = r;
    tick();
    ready_add_subt = 1'b0;
    check({nm, " ready_out"}, 64'(ready_out), 64'(oh));
    check({nm, " result"}, 64'(result_out), 64'(r));
    ack_in = oh;
    req_in = 2'b00;
    tick();
    check({nm, " ack_add_subt"}, 64'(ack_add_subt), 64'd1);
    ack_in = 2'b00;
    tick();
    check({nm, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [1:0]  oh;
    logic [31:0] exp_a;
    logic [31:0] a_hold;
    logic [1:0]  req_s;
    logic [31:0] ra_s[NR];
    logic [31:0] rb_s[NR];
    logic        rop_s[NR];
    logic [31:0] exp_res;
    int          exp_w;
    int          exp_ptr;
    int          outstanding;
    int          served[NR];
    int          w;

    vecs[0] = '{2'b11, 2'b00, 32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044,
                32'h0A0A0A0A, 3, 0};
    vecs[1] = '{2'b11, 2'b10, 32'h00000111, 32'h00000222, 32'h00000333, 32'h00000444,
                32'h0B0B0B0B, 1, 1};
    vecs[2] = '{2'b11, 2'b01, 32'h00001111, 32'h00002222, 32'h00003333, 32'h00004444,
                32'h0C0C0C0C, 2, 0};
    vecs[3] = '{2'b01, 2'b00, 32'h3F800000, 32'h40000000, 32'h12345678, 32'h9ABCDEF0,
                32'h40400000, 5, 0};
    vecs[4] = '{2'b10, 2'b00, 32'hFFFFFFFF, 32'h00000000, 32'h40A00000, 32'h3F800000,
                32'h40C00000, 4, 1};
    vecs[5] = '{2'b10, 2'b10, 32'h00000000, 32'h00000000, 32'h41200000, 32'h40000000,
                32'h41000000, 1, 1};

    for (int i = 0; i < NR; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      rop[i] = 1'b0;
    end

    // Reset state
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset ready_out", 64'(ready_out), 64'd0);
    check("reset result", 64'(result_out), 64'd0);
    check("reset grant_id", 64'(grant_id), 64'd0);
    check("reset beg", 64'(beg_add_subt), 64'd0);
    check("reset ack", 64'(ack_add_subt), 64'd0);
    check("reset data_a", 64'(data_a_add_subt), 64'd0);
    @(posedge clk);
    #3 reset = 1'b0;

    // Vector table
    unit_en = 1'b1;
    use_ovr = 1'b1;
    foreach (vecs[v]) begin
      ra[0] = vecs[v].a0; rb[0] = vecs[v].b0; rop[0] = vecs[v].op[0];
      ra[1] = vecs[v].a1; rb[1] = vecs[v].b1; rop[1] = vecs[v].op[1];
      drive_ops();
      req_in   = vecs[v].req;
      ovr_val  = vecs[v].res;
      unit_dly = vecs[v].dly;
      oh       = 2'b01 << vecs[v].gid;
      exp_a    = (vecs[v].gid == 1) ? vecs[v].a1 : vecs[v].a0;
      tick();
      check($sformatf("v%0d beg", v), 64'(beg_add_subt), 64'd1);
      check($sformatf("v%0d grant_id", v), 64'(grant_id), 64'(vecs[v].gid));
      check($sformatf("v%0d data_a", v), 64'(data_a_add_subt), 64'(exp_a));
      check($sformatf("v%0d data_b", v), 64'(data_b_add_subt),
            64'((vecs[v].gid == 1) ? vecs[v].b1 : vecs[v].b0));
      check($sformatf("v%0d op", v), 64'(operation_add_subt), 64'(vecs[v].op[vecs[v].gid]));
      data_a_in = {$urandom, $urandom};
      tick();
      check($sformatf("v%0d beg one cycle", v), 64'(beg_add_subt), 64'd0);
      wait_ready();
      check($sformatf("v%0d ready_out", v), 64'(ready_out), 64'(oh));
      check($sformatf("v%0d result", v), 64'(result_out), 64'(vecs[v].res));
      check($sformatf("v%0d ready latency", v), 64'(cyc - rdy_cyc), 64'd1);
      check($sformatf("v%0d data_a held", v), 64'(data_a_add_subt), 64'(exp_a));
      ack_in = oh;
      req_in = 2'b00;
      tick();
      check($sformatf("v%0d ack_add_subt", v), 64'(ack_add_subt), 64'd1);
      check($sformatf("v%0d ready drop", v), 64'(ready_out), 64'd0);
      ack_in = 2'b00;
      tick();
      check($sformatf("v%0d ack one cycle", v), 64'(ack_add_subt), 64'd0);
      check($sformatf("v%0d busy", v), 64'(busy), 64'd0);
    end
    use_ovr = 1'b0;

    // Wrong-requester ack is ignored in DONE (rr pointer now 0, only requester 1 asks)
    unit_dly = 2;
    req_in = 2'b10;
    tick();
    wait_ready();
    for (int k = 0; k < 3; k++) begin
      ack_in = 2'b01;
      tick();
      check($sformatf("wrong ack %0d ready_out", k), 64'(ready_out), 64'b10);
      check($sformatf("wrong ack %0d no ack_add_subt", k), 64'(ack_add_subt), 64'd0);
    end
    ack_in = 2'b10;
    req_in = 2'b00;
    tick();
    check("right ack ack_add_subt", 64'(ack_add_subt), 64'd1);
    ack_in = 2'b00;
    tick();

    // ack_in already high on DONE entry: DONE lasts one cycle
    unit_en = 1'b0;
    req_in = 2'b10;
    tick();
    check("early ack grant", 64'(grant_id), 64'd1);
    tick();
    ack_in = 2'b10;
    ready_add_subt  = 1'b1;
    result_add_subt = 32'hCAFEF00D;
    tick();
    ready_add_subt = 1'b0;
    check("early ack ready_out", 64'(ready_out), 64'b10);
    tick();
    check("early ack release", 64'(ack_add_subt), 64'd1);
    check("early ack ready drop", 64'(ready_out), 64'd0);
    ack_in = 2'b00;
    req_in = 2'b00;
    tick();

    // Ready during LAUNCH is ignored; operand change after grant has no effect
    ra[0] = 32'h13572468;
    drive_ops();
    a_hold = ra[0];
    req_in = 2'b01;
    tick();
    ready_add_subt  = 1'b1;
    result_add_subt = 32'hDEAD0001;
    tick();
    ready_add_subt = 1'b0;
    check("launch ready ignored busy", 64'(busy), 64'd1);
    check("launch ready ignored ready_out", 64'(ready_out), 64'd0);
    data_a_in[31:0] = 32'h0BADBEEF;
    tick();
    tick();
    check("launch ready still waiting", 64'(ready_out), 64'd0);
    check("operand change wait", 64'(data_a_add_subt), 64'(a_hold));
    ready_add_subt  = 1'b1;
    result_add_subt = 32'h12345678;
    tick();
    ready_add_subt = 1'b0;
    check("late ready ready_out", 64'(ready_out), 64'b01);
    check("late ready result", 64'(result_out), 64'h12345678);
    check("operand change done", 64'(data_a_add_subt), 64'(a_hold));
    ack_in = 2'b01;
    req_in = 2'b00;
    tick();
    check("late ready ack_add_subt", 64'(ack_add_subt), 64'd1);
    check("operand change release", 64'(data_a_add_subt), 64'(a_hold));
    ack_in = 2'b00;
    tick();

    // Asynchronous reset in WAIT while the rr pointer is 1
    req_in = 2'b10;
    tick();
    tick();
    check("pre-reset busy", 64'(busy), 64'd1);
    #3 reset = 1'b1;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset grant_id", 64'(grant_id), 64'd0);
    check("async reset data_a", 64'(data_a_add_subt), 64'd0);
    check("async reset beg/ack/ready", {62'd0, ready_out} | 64'(beg_add_subt) |
          64'(ack_add_subt) | 64'(result_out), 64'd0);
    req_in = 2'b00;
    @(posedge clk);
    #4 reset = 1'b0;
    req_in = 2'b11;
    tick();
    check("post-reset rr_ptr grant", 64'(grant_id), 64'd0);
    check("post-reset beg", 64'(beg_add_subt), 64'd1);
    finish_txn("post-reset txn0", 2'b01, 32'h0F0F0F0F);
    req_in = 2'b10;
    tick();
    check("post-reset req10 grant", 64'(grant_id), 64'd1);
    finish_txn("post-reset txn1", 2'b10, 32'hF0F0F0F0);

    // Randomized traffic against the reference model
    unit_en = 1'b1;
    cnt = 0;
    exp_ptr = 0;
    outstanding = 0;
    exp_w = 0;
    exp_res = '0;
    served[0] = 0;
    served[1] = 0;
    for (int t = 0; t < 480; t++) begin
      req_s = req_in;
      ra_s = ra;
      rb_s = rb;
      rop_s = rop;
      unit_dly = $urandom_range(1, 4);
      tick();
      if (beg_add_subt) begin
        w = rr_pick(req_s, exp_ptr);
        check("rand single outstanding", 64'(outstanding), 64'd0);
        check("rand grant_id", 64'(grant_id), 64'(w));
        if (w >= 0) begin
          check("rand data_a", 64'(data_a_add_subt), 64'(ra_s[w]));
          check("rand data_b", 64'(data_b_add_subt), 64'(rb_s[w]));
          check("rand op", 64'(operation_add_subt), 64'(rop_s[w]));
          exp_res = unit_fn(ra_s[w], rb_s[w], rop_s[w]);
          exp_w = w;
          served[w]++;
        end
        outstanding = 1;
      end
      if (ready_out != 2'b00) begin
        check("rand ready_out", 64'(ready_out), 64'(2'b01 << exp_w));
        check("rand result", 64'(result_out), 64'(exp_res));
      end
      if (ack_add_subt) begin
        check("rand ack outstanding", 64'(outstanding), 64'd1);
        exp_ptr = (exp_w + 1) % NR;
        outstanding = 0;
      end
      ack_in = 2'b00;
      for (int i = 0; i < NR; i++) begin
        if (ready_out[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            ack_in[i] = 1'b1;
            req_in[i] = 1'b0;
          end
        end else if (!req_in[i] && t < 400 && $urandom_range(0, 2) == 0) begin
          req_in[i] = 1'b1;
          ra[i] = $urandom;
          rb[i] = $urandom;
          rop[i] = 1'($urandom_range(0, 1));
        end else begin
          if ($urandom_range(0, 4) == 0) ack_in[i] = 1'b1;
          if (!req_in[i] || (outstanding == 1 && exp_w == i)) ra[i] = $urandom;
        end
      end
      drive_ops();
    end
    check("rand drained req", 64'(req_in), 64'd0);
    check("rand drained busy", 64'(busy), 64'd0);
    check("rand both served", 64'((served[0] > 0) && (served[1] > 0)), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
